analog_io_sequencer: RTL
========================

ANALOG_IO_SEQUENCER -- requirements
Module: analog_io_sequencer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, Wishbone base address; offsets 0x0..0xC.
REQ-002 SHALL have parameter SETTLE_RST, default 16'd1000, reset value of SETTLE register in wb_clk_i cycles.
REQ-003 SHALL have port wb_clk_i  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port wb_rst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports wbs_cyc_i, wbs_stb_i, wbs_we_i  input  1 each  Wishbone classic slave controls.
REQ-006 SHALL have ports wbs_adr_i, wbs_dat_i  input  32 each; wbs_sel_i  input  4  byte lanes.
REQ-007 SHALL have ports wbs_dat_o  output  32 and wbs_ack_o  output  1.
REQ-008 SHALL have port io_oeb_o  output  6  analog pad group gate; bit=0 means pad released to analog function; [1:0] VB_A/VB_B, [2] IB, [4:3] IN_P/IN_M, [5] OUT.
REQ-009 SHALL have ports ready_o, busy_o, irq_o  output  1 each: fully on, ramp in progress, sequence-done interrupt.

Function
REQ-010 Registers: CTRL 0x0 (bit0 EN, bit1 FORCE_OFF self-clearing), SETTLE 0x4 ([15:0]), STATUS 0x8 RO (bits[2:0] stage, [4:3] state, bit5 ready), IRQ 0xC (bit0 pending, write-1-to-clear).
REQ-011 Access hits when cyc&stb and adr[31:4]==BASE_ADDR[31:4]; ack SHALL be a single-cycle pulse one cycle after the hit; no back-to-back ack while stb held (ack, then one idle cycle minimum).
REQ-012 Writes honour wbs_sel_i per byte; reads of unused bits return 0; non-hit offsets within the window ack with data 0.
REQ-013 Stage s (0..4) maps io_oeb_o: 0->6'b111111, 1->6'b111100, 2->6'b111000, 3->6'b100000, 4->6'b000000; io_oeb_o SHALL be registered.
REQ-014 FSM states: OFF (stage 0), RAMP_UP, HOLD_ON (stage 4), RAMP_DOWN.
REQ-015 OFF: EN=1 -> next edge stage=1, timer=SETTLE, RAMP_UP.
REQ-016 RAMP_UP/RAMP_DOWN: timer decrements each cycle; at edge where timer==0, stage +1 (up) / -1 (down) and timer reloads SETTLE; each stage lasts SETTLE+1 cycles.
REQ-017 RAMP_UP at stage 4 with timer==0 -> HOLD_ON, ready_o=1, IRQ pending set.
REQ-018 HOLD_ON: EN=0 -> RAMP_DOWN, ready_o=0, stage held, timer=SETTLE.
REQ-019 RAMP_DOWN reaching stage 0 -> OFF, IRQ pending set.
REQ-020 EN change mid-ramp SHALL reverse direction on next edge, keep current stage, reload timer.
REQ-021 FORCE_OFF=1 SHALL force stage 0, OFF, EN cleared, timer 0 on next edge from any state; no IRQ; takes priority over simultaneous EN write.
REQ-022 SETTLE writes during a ramp SHALL take effect at the next reload only.
REQ-023 SETTLE=0 SHALL give one cycle per stage.
REQ-024 busy_o=1 in RAMP_UP/RAMP_DOWN; irq_o = IRQ pending; W1C and simultaneous set: set wins.

Reset
REQ-025 On wb_rst_n_i low: state OFF, stage 0, io_oeb_o=6'b111111, CTRL=0, SETTLE=SETTLE_RST, timer=0, IRQ pending=0, wbs_ack_o=0, wbs_dat_o=0, ready_o=busy_o=0.
REQ-026 Reset mid-ramp SHALL drop all pads to 6'b111111 immediately (asynchronously); deassertion synchronised externally.

Structure
REQ-027 Package aio_seq_pkg SHALL hold register offsets, CTRL bit indices, FSM state enum, and stage-to-oeb table.
REQ-028 Sub-module aio_seq_wb_regs SHALL implement Wishbone decode and registers; FSM and timer in top.

Verification
REQ-029 Reset release, read STATUS -> 0; read SETTLE -> 1000; io_oeb_o=6'b111111.
REQ-030 SETTLE=3, write EN=1 -> oeb 111100, 111000, 100000, 000000 each 4 cycles, then ready_o=1, irq_o=1 at 16 cycles after stage 1.
REQ-031 From HOLD_ON, EN=0 -> reverse stages 4 cycles each; OFF, irq_o=1; W1C IRQ -> irq_o=0.
REQ-032 SETTLE=5, EN=1, EN=0 at stage 3 mid-timer -> stage 3 held 6 cycles then 2,1,0.
REQ-033 During RAMP_UP write CTRL=0x3 -> next edge oeb=111111, EN read back 0, no irq.
REQ-034 Assert wb_rst_n_i low at stage 2 -> oeb=111111 same cycle, all registers at reset values.

Source files
------------

// File: rtl/aio_seq_pkg.sv
// Shared definitions for the analog pad sequencer: register map, CTRL bits,
// FSM states and the stage-to-pad-gate table.
package aio_seq_pkg;

  localparam logic [3:0] OFS_CTRL   = 4'h0;
  localparam logic [3:0] OFS_SETTLE = 4'h4;
  localparam logic [3:0] OFS_STATUS = 4'h8;
  localparam logic [3:0] OFS_IRQ    = 4'hC;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_FORCE_OFF = 1;

  localparam logic [2:0] STAGE_MAX = 3'd4;

  typedef enum logic [1:0] {
    ST_OFF       = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_HOLD_ON   = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } aio_state_e;

  // Entry [s] is the pad gate for stage s; 0 releases a pad to its analog role.
  localparam logic [4:0][5:0] OEB_TBL = {
    6'b000000, 6'b100000, 6'b111000, 6'b111100, 6'b111111
  };

  function automatic logic [5:0] stage_oeb(input logic [2:0] s);
    return (s > STAGE_MAX) ? 6'b111111 : OEB_TBL[s];
  endfunction

endpackage

// File: rtl/aio_seq_wb_regs.sv
// Wishbone classic slave: address decode, CTRL/SETTLE/STATUS/IRQ registers,
// single-cycle ack with a forced idle cycle between acks.
module aio_seq_wb_regs
  import aio_seq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter logic [15:0] SETTLE_RST = 16'd1000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  input  logic [2:0]  stage_i,
  input  aio_state_e  state_i,
  input  logic        ready_i,
  input  logic        irq_set_i,
  output logic        en_o,
  output logic        force_off_o,
  output logic [15:0] settle_o,
  output logic        irq_o
);

  logic        ack_q, en_q, force_q, irq_q;
  logic [31:0] dat_q, rdata;
  logic [15:0] settle_q;
  logic        hit, reg_ok, wr, wr_ctrl, wr_settle, wr_irq;
  logic [3:0]  ofs;
  logic        unused_bits;

  assign ofs       = wbs_adr_i[3:0];
  assign hit       = wbs_cyc_i && wbs_stb_i && !ack_q &&
                     (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign reg_ok    = (wbs_adr_i[1:0] == 2'b00);
  assign wr        = hit && wbs_we_i && reg_ok;
  assign wr_ctrl   = wr && (ofs == OFS_CTRL) && wbs_sel_i[0];
  assign wr_settle = wr && (ofs == OFS_SETTLE);
  assign wr_irq    = wr && (ofs == OFS_IRQ) && wbs_sel_i[0];
  assign unused_bits = ^{wbs_dat_i[31:16], wbs_sel_i[3:2]};

  always_comb begin
    rdata = '0;
    if (reg_ok) begin
      case (ofs)
        OFS_CTRL:   rdata = {30'b0, force_q, en_q};
        OFS_SETTLE: rdata = {16'b0, settle_q};
        OFS_STATUS: rdata = {26'b0, ready_i, state_i, stage_i};
        OFS_IRQ:    rdata = {31'b0, irq_q};
        default:    rdata = '0;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      en_q     <= 1'b0;
      force_q  <= 1'b0;
      settle_q <= SETTLE_RST;
      irq_q    <= 1'b0;
    end else begin
      ack_q   <= hit;
      dat_q   <= (hit && !wbs_we_i) ? rdata : '0;
      force_q <= wr_ctrl && wbs_dat_i[CTRL_FORCE_OFF];
      // FORCE_OFF in the same write wins over EN.
      if (wr_ctrl)
        en_q <= wbs_dat_i[CTRL_EN] && !wbs_dat_i[CTRL_FORCE_OFF];
      else if (force_q)
        en_q <= 1'b0;
      if (wr_settle && wbs_sel_i[0]) settle_q[7:0]  <= wbs_dat_i[7:0];
      if (wr_settle && wbs_sel_i[1]) settle_q[15:8] <= wbs_dat_i[15:8];
      if (irq_set_i)
        irq_q <= 1'b1;
      else if (wr_irq && wbs_dat_i[0])
        irq_q <= 1'b0;
    end
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign en_o        = en_q;
  assign force_off_o = force_q;
  assign settle_o    = settle_q;
  assign irq_o       = irq_q;

endmodule

// File: rtl/analog_io_sequencer.sv
// Steps the analog pad group through five gate stages with a programmable
// settle time per stage; reverses on EN change, FORCE_OFF drops everything.
module analog_io_sequencer
  import aio_seq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter logic [15:0] SETTLE_RST = 16'd1000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic [5:0]  io_oeb_o,
  output logic        ready_o,
  output logic        busy_o,
  output logic        irq_o
);

  logic        en, force_off, irq_set;
  logic [15:0] settle;

  aio_state_e  state_q;
  logic [2:0]  stage_q;
  logic [15:0] timer_q;
  logic [5:0]  oeb_q;
  logic        ready_q, busy_q;

  aio_seq_wb_regs #(.BASE_ADDR(BASE_ADDR), .SETTLE_RST(SETTLE_RST)) u_regs (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_n_i  (wb_rst_n_i),
    .wbs_cyc_i   (wbs_cyc_i),
    .wbs_stb_i   (wbs_stb_i),
    .wbs_we_i    (wbs_we_i),
    .wbs_adr_i   (wbs_adr_i),
    .wbs_dat_i   (wbs_dat_i),
    .wbs_sel_i   (wbs_sel_i),
    .wbs_dat_o   (wbs_dat_o),
    .wbs_ack_o   (wbs_ack_o),
    .stage_i     (stage_q),
    .state_i     (state_q),
    .ready_i     (ready_q),
    .irq_set_i   (irq_set),
    .en_o        (en),
    .force_off_o (force_off),
    .settle_o    (settle),
    .irq_o       (irq_o)
  );

  // Combinational so IRQ pending rises on the same edge as the terminal state.
  assign irq_set = !force_off && (timer_q == 16'd0) &&
                   (((state_q == ST_RAMP_UP)   &&  en && (stage_q == STAGE_MAX)) ||
                    ((state_q == ST_RAMP_DOWN) && !en && (stage_q == 3'd1)));

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= ST_OFF;
      stage_q <= 3'd0;
      timer_q <= 16'd0;
      oeb_q   <= 6'b111111;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (force_off) begin
      state_q <= ST_OFF;
      stage_q <= 3'd0;
      timer_q <= 16'd0;
      oeb_q   <= stage_oeb(3'd0);
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_OFF: if (en) begin
          state_q <= ST_RAMP_UP;
          stage_q <= 3'd1;
          oeb_q   <= stage_oeb(3'd1);
          timer_q <= settle;
          busy_q  <= 1'b1;
        end
        ST_RAMP_UP: begin
          if (!en) begin
            state_q <= ST_RAMP_DOWN;
            timer_q <= settle;
          end else if (timer_q != 16'd0) begin
            timer_q <= timer_q - 16'd1;
          end else if (stage_q == STAGE_MAX) begin
            state_q <= ST_HOLD_ON;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            stage_q <= stage_q + 3'd1;
            oeb_q   <= stage_oeb(stage_q + 3'd1);
            timer_q <= settle;
          end
        end
        ST_HOLD_ON: if (!en) begin
          state_q <= ST_RAMP_DOWN;
          timer_q <= settle;
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
        end
        ST_RAMP_DOWN: begin
          if (en) begin
            state_q <= ST_RAMP_UP;
            timer_q <= settle;
          end else if (timer_q != 16'd0) begin
            timer_q <= timer_q - 16'd1;
          end else if (stage_q <= 3'd1) begin
            state_q <= ST_OFF;
            stage_q <= 3'd0;
            oeb_q   <= stage_oeb(3'd0);
            busy_q  <= 1'b0;
          end else begin
            stage_q <= stage_q - 3'd1;
            oeb_q   <= stage_oeb(stage_q - 3'd1);
            timer_q <= settle;
          end
        end
        default: state_q <= ST_OFF;
      endcase
    end
  end

  assign io_oeb_o = oeb_q;
  assign ready_o  = ready_q;
  assign busy_o   = busy_q;

endmodule
